image_sender: RTL

//  Transmit side of the UART image link: accepts 16-bit words (results/pixels) on a valid/ready

---
 rtl/uart_avm_pkg.sv | 23 ++
 rtl/word_fifo.sv | 55 +++++
 rtl/image_sender.sv | 156 +++++++++++++++
 3 files changed

// File: rtl/uart_avm_pkg.sv
// Shared definitions for the UART image link (transmit sender and receive loader).
// Register map of the RS232 UART core as seen over Avalon-MM, status bit
// positions, the sender FSM state type and a small byte-select helper.
package uart_avm_pkg;

  localparam logic [4:0] RX_BASE     = 5'd0;
  localparam logic [4:0] TX_BASE     = 5'd4;
  localparam logic [4:0] STATUS_BASE = 5'd8;
  localparam int         TX_OK_BIT   = 6;
  localparam int         RX_OK_BIT   = 7;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_POLL  = 2'd1,
    S_WRITE = 2'd2
  } sender_state_t;

  // Low byte goes out first, high byte second.
  function automatic logic [7:0] select_byte(input logic [15:0] word, input logic hi);
    return hi ? word[15:8] : word[7:0];
  endfunction

endpackage

// File: rtl/word_fifo.sv
// Parameterised synchronous FIFO with push/pop and full/empty flags.
// DEPTH must be a power of two so the pointers wrap naturally.
// A push while full or a pop while empty is ignored.
module word_fifo #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 4
) (
  input  logic             i_clk,
  input  logic             avm_rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             full,
  output logic             empty
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             do_push;
  logic             do_pop;

  assign full     = (count == (AW+1)'(DEPTH));
  assign empty    = (count == '0);
  assign do_push  = push && !full;
  assign do_pop   = pop && !empty;
  assign pop_data = mem[rd_ptr];

  // Pointer and occupancy bookkeeping; pointers wrap modulo DEPTH
  always_ff @(posedge i_clk or negedge avm_rst_n) begin
    if (!avm_rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage array; contents need no reset because empty hides them
  always_ff @(posedge i_clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/image_sender.sv
// Transmit side of the UART image link. Buffers 16-bit words in a small FIFO
// and writes them low byte first to the UART TX register over Avalon-MM,
// polling the TRDY status bit before every byte.
// Optional build macro IMAGE_SENDER_CHECKSUM_EN appends an 8-bit XOR checksum
// byte after the last word of every frame.
module image_sender
  import uart_avm_pkg::*;
#(
  parameter int FIFO_DEPTH  = 4,
  parameter int FRAME_WORDS = 64
) (
  input  logic        i_clk,
  input  logic        avm_rst_n,
  input  logic [15:0] i_data,
  input  logic        i_valid,
  output logic        o_ready,
  output logic        o_frame_done,
  output logic [4:0]  avm_address,
  output logic        avm_read,
  input  logic [31:0] avm_readdata,
  output logic        avm_write,
  output logic [31:0] avm_writedata,
  input  logic        avm_waitrequest
);

  sender_state_t state;
  logic [15:0]   word_r;
  logic [1:0]    byte_sel;
  logic [15:0]   frame_cnt;
  logic [7:0]    cur_byte;
  logic          frame_last;
  logic          fifo_full;
  logic          fifo_empty;
  logic          fifo_pop;
  logic [15:0]   fifo_rd_data;
  logic          unused_readdata;

  assign unused_readdata = ^{avm_readdata[31:7], avm_readdata[5:0]};

  assign o_ready    = !fifo_full;
  assign fifo_pop   = (state == S_IDLE) && !fifo_empty;
  assign frame_last = (frame_cnt == 16'(FRAME_WORDS - 1));

  word_fifo #(
    .WIDTH (16),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .i_clk     (i_clk),
    .avm_rst_n (avm_rst_n),
    .push      (i_valid),
    .push_data (i_data),
    .pop       (fifo_pop),
    .pop_data  (fifo_rd_data),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

`ifdef IMAGE_SENDER_CHECKSUM_EN
  logic [7:0] checksum;

  // Running XOR of the frame's data bytes; cleared once the checksum byte is accepted
  always_ff @(posedge i_clk or negedge avm_rst_n) begin
    if (!avm_rst_n) begin
      checksum <= 8'd0;
    end else if (state == S_WRITE && !avm_waitrequest) begin
      if (byte_sel == 2'd2) checksum <= 8'd0;
      else                  checksum <= checksum ^ cur_byte;
    end
  end

  // Byte to transmit: data bytes, or the checksum when byte_sel reaches 2
  always_comb begin
    cur_byte = select_byte(word_r, byte_sel[0]);
    if (byte_sel == 2'd2) cur_byte = checksum;
  end
`else
  // Byte to transmit for the current byte_sel
  always_comb begin
    cur_byte = select_byte(word_r, byte_sel[0]);
  end
`endif

  // Transfer sequencer: pop a word, then poll TRDY and write each byte in turn
  always_ff @(posedge i_clk or negedge avm_rst_n) begin
    if (!avm_rst_n) begin
      state         <= S_IDLE;
      word_r        <= 16'd0;
      byte_sel      <= 2'd0;
      frame_cnt     <= 16'd0;
      avm_read      <= 1'b0;
      avm_write     <= 1'b0;
      avm_address   <= STATUS_BASE;
      avm_writedata <= 32'd0;
      o_frame_done  <= 1'b0;
    end else begin
      o_frame_done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (!fifo_empty) begin
            word_r      <= fifo_rd_data;
            byte_sel    <= 2'd0;
            avm_read    <= 1'b1;
            avm_address <= STATUS_BASE;
            state       <= S_POLL;
          end
        end
        S_POLL: begin
          if (!avm_waitrequest && avm_readdata[TX_OK_BIT]) begin
            avm_read      <= 1'b0;
            avm_write     <= 1'b1;
            avm_address   <= TX_BASE;
            avm_writedata <= {24'd0, cur_byte};
            state         <= S_WRITE;
          end
        end
        S_WRITE: begin
          if (!avm_waitrequest) begin
            avm_write   <= 1'b0;
            avm_address <= STATUS_BASE;
            if (byte_sel == 2'd0) begin
              byte_sel <= 2'd1;
              avm_read <= 1'b1;
              state    <= S_POLL;
            end
`ifdef IMAGE_SENDER_CHECKSUM_EN
            else if (byte_sel == 2'd2) begin
              byte_sel     <= 2'd0;
              o_frame_done <= 1'b1;
              state        <= S_IDLE;
            end else if (frame_last) begin
              frame_cnt <= 16'd0;
              byte_sel  <= 2'd2;
              avm_read  <= 1'b1;
              state     <= S_POLL;
            end
`else
            else if (frame_last) begin
              frame_cnt    <= 16'd0;
              byte_sel     <= 2'd0;
              o_frame_done <= 1'b1;
              state        <= S_IDLE;
            end
`endif
            else begin
              frame_cnt <= frame_cnt + 16'd1;
              byte_sel  <= 2'd0;
              state     <= S_IDLE;
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
